// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a latched PAT_W-bit pattern MSB-first,
// repeated a requested number of frames with idle gaps between them, and
// shows the completed-frame count on two active-high 7-segment digits.
module serial_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int GAP   = 2
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [3:0]       repeats,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [3:0]       counter,
  output logic             a1,
  output logic             b1,
  output logic             c1,
  output logic             d1,
  output logic             e1,
  output logic             f1,
  output logic             g1,
  output logic             a2,
  output logic             b2,
  output logic             c2,
  output logic             d2,
  output logic             e2,
  output logic             f2,
  output logic             g2
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
  localparam logic [3:0] GAP_TOP = 4'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [3:0]       remaining_q, remaining_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic [3:0]       counter_q, counter_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0]       ones_digit;
  logic [3:0]       tens_digit;

  // Maps a decimal digit to active-high abcdefg segments.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  // Next-state logic: request acceptance, bit stepping, frame/gap sequencing.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    pattern_d   = pattern_q;
    remaining_d = remaining_q;
    gap_cnt_d   = gap_cnt_q;
    counter_d   = counter_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (repeats != 4'd0) begin
            pattern_d   = pattern;
            remaining_d = repeats;
            index_d     = IDX_TOP;
            state_d     = S_SEND;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SEND: begin
        if (index_q == '0) begin
          counter_d   = counter_q + 4'd1;
          remaining_d = remaining_q - 4'd1;
          if (remaining_q == 4'd1) begin
            state_d = S_DONE;
          end else if (GAP > 0) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_TOP;
          end else begin
            index_d = IDX_TOP;
          end
        end else begin
          index_d = index_q - 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = S_SEND;
          index_d = IDX_TOP;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values are derived from the upcoming state so they register alongside it.
  always_comb begin
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      S_SEND: begin
        out_d       = pattern_d[index_d];
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      S_GAP: begin
        busy_d = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        out_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight request.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= S_IDLE;
      index_q     <= '0;
      pattern_q   <= '0;
      remaining_q <= 4'd0;
      gap_cnt_q   <= 4'd0;
      counter_q   <= 4'd0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      pattern_q   <= pattern_d;
      remaining_q <= remaining_d;
      gap_cnt_q   <= gap_cnt_d;
      counter_q   <= counter_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Split the 0..15 frame count into decimal tens and ones.
  always_comb begin
    ones_digit = counter_q;
    tens_digit = 4'd0;
    if (counter_q >= 4'd10) begin
      ones_digit = counter_q - 4'd10;
      tens_digit = 4'd1;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign counter   = counter_q;

  assign {a1, b1, c1, d1, e1, f1, g1} = seg7(ones_digit);
  assign {a2, b2, c2, d2, e2, f2, g2} = seg7(tens_digit);

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Testbench for serial_pattern_tx: two instances (GAP=2 and GAP=0) share
// stimulus; a per-cycle scoreboard of expected outputs is built when each
// request is issued and checked as the DUTs produce output.
module tb_serial_pattern_tx;

  typedef struct packed {
    logic       dout;
    logic       valid;
    logic       busy;
    logic       done;
    logic [3:0] cnt;
  } exp_t;

  logic       CLK;
  logic       reset;
  logic       start;
  logic [3:0] pattern;
  logic [3:0] repeats;

  logic       out_a, valid_a, busy_a, done_a;
  logic [3:0] counter_a;
  logic [6:0] seg1_a, seg2_a;
  logic       out_b, valid_b, busy_b, done_b;
  logic [3:0] counter_b;
  logic [6:0] seg1_b, seg2_b;

  exp_t q_a[$];
  exp_t q_b[$];
  logic [3:0] model_cnt;
  int checks;
  int errors;

  serial_pattern_tx #(.PAT_W(4), .GAP(2)) dut_a (
    .CLK(CLK), .reset(reset), .start(start), .pattern(pattern), .repeats(repeats),
    .out(out_a), .out_valid(valid_a), .busy(busy_a), .done(done_a), .counter(counter_a),
    .a1(seg1_a[6]), .b1(seg1_a[5]), .c1(seg1_a[4]), .d1(seg1_a[3]),
    .e1(seg1_a[2]), .f1(seg1_a[1]), .g1(seg1_a[0]),
    .a2(seg2_a[6]), .b2(seg2_a[5]), .c2(seg2_a[4]), .d2(seg2_a[3]),
    .e2(seg2_a[2]), .f2(seg2_a[1]), .g2(seg2_a[0])
  );

  serial_pattern_tx #(.PAT_W(4), .GAP(0)) dut_b (
    .CLK(CLK), .reset(reset), .start(start), .pattern(pattern), .repeats(repeats),
    .out(out_b), .out_valid(valid_b), .busy(busy_b), .done(done_b), .counter(counter_b),
    .a1(seg1_b[6]), .b1(seg1_b[5]), .c1(seg1_b[4]), .d1(seg1_b[3]),
    .e1(seg1_b[2]), .f1(seg1_b[1]), .g1(seg1_b[0]),
    .a2(seg2_b[6]), .b2(seg2_b[5]), .c2(seg2_b[4]), .d2(seg2_b[3]),
    .e2(seg2_b[2]), .f2(seg2_b[1]), .g2(seg2_b[0])
  );

  // Free-running clock, period 10.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_of = 7'b1111110;
      4'd1:    seg_of = 7'b0110000;
      4'd2:    seg_of = 7'b1101101;
      4'd3:    seg_of = 7'b1111001;
      4'd4:    seg_of = 7'b0110011;
      4'd5:    seg_of = 7'b1011011;
      4'd6:    seg_of = 7'b1011111;
      4'd7:    seg_of = 7'b1110000;
      4'd8:    seg_of = 7'b1111111;
      4'd9:    seg_of = 7'b1111011;
      default: seg_of = 7'b0000000;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int which, input exp_t e);
    if (which == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  task automatic push_idle(input int n);
    exp_t e;
    e = '{dout: 1'b0, valid: 1'b0, busy: 1'b0, done: 1'b0, cnt: model_cnt};
    for (int i = 0; i < n; i++) begin
      push(0, e);
      push(1, e);
    end
  endtask

  // Builds the cycle-by-cycle expectation of a request for both gap settings.
  task automatic model_req(input logic [3:0] pat, input logic [3:0] rep);
    exp_t e;
    logic [3:0] c;
    int gap;
    for (int w = 0; w < 2; w++) begin
      gap = (w == 0) ? 2 : 0;
      c = model_cnt;
      for (int f = 0; f < int'(rep); f++) begin
        for (int b = 3; b >= 0; b--) begin
          e = '{dout: pat[b], valid: 1'b1, busy: 1'b1, done: 1'b0, cnt: c};
          push(w, e);
        end
        c = c + 4'd1;
        if (f < int'(rep) - 1) begin
          for (int g = 0; g < gap; g++) begin
            e = '{dout: 1'b0, valid: 1'b0, busy: 1'b1, done: 1'b0, cnt: c};
            push(w, e);
          end
        end
      end
      e = '{dout: 1'b0, valid: 1'b0, busy: 1'b0, done: 1'b1, cnt: c};
      push(w, e);
      e = '{dout: 1'b0, valid: 1'b0, busy: 1'b0, done: 1'b0, cnt: c};
      push(w, e);
    end
    model_cnt = model_cnt + rep;
  endtask

  // Drives a one-cycle start pulse at a falling edge and records expectations.
  task automatic applyStimulus(input logic [3:0] pat, input logic [3:0] rep);
    pattern = pat;
    repeats = rep;
    start   = 1'b1;
    model_req(pat, rep);
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Waits, with a cycle budget, for both scoreboards to empty.
  task automatic drain();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("drain_pending", 8'(q_a.size() + q_b.size()), 8'd0);
  endtask

  // Compares every DUT output against the scoreboard one step after each edge.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (q_a.size() != 0) begin
      e = q_a.pop_front();
      checkOutput("A_out", 8'(out_a), 8'(e.dout));
      checkOutput("A_out_valid", 8'(valid_a), 8'(e.valid));
      checkOutput("A_busy", 8'(busy_a), 8'(e.busy));
      checkOutput("A_done", 8'(done_a), 8'(e.done));
      checkOutput("A_counter", 8'(counter_a), 8'(e.cnt));
      checkOutput("A_ones", 8'(seg1_a), 8'(seg_of(e.cnt % 4'd10)));
      checkOutput("A_tens", 8'(seg2_a), 8'(seg_of(e.cnt / 4'd10)));
    end
    if (q_b.size() != 0) begin
      e = q_b.pop_front();
      checkOutput("B_out", 8'(out_b), 8'(e.dout));
      checkOutput("B_out_valid", 8'(valid_b), 8'(e.valid));
      checkOutput("B_busy", 8'(busy_b), 8'(e.busy));
      checkOutput("B_done", 8'(done_b), 8'(e.done));
      checkOutput("B_counter", 8'(counter_b), 8'(e.cnt));
      checkOutput("B_ones", 8'(seg1_b), 8'(seg_of(e.cnt % 4'd10)));
      checkOutput("B_tens", 8'(seg2_b), 8'(seg_of(e.cnt / 4'd10)));
    end
  end

  // Directed sequence of scenarios.
  initial begin
    checks    = 0;
    errors    = 0;
    model_cnt = 4'd0;
    reset     = 1'b1;
    start     = 1'b1;
    pattern   = 4'b1111;
    repeats   = 4'd1;

    $display("[TB] reset held 3 cycles with start asserted");
    push_idle(3);
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    start = 1'b0;
    push_idle(2);
    drain();

    $display("[TB] single frame 1011");
    applyStimulus(4'b1011, 4'd1);
    drain();

    $display("[TB] three frames 0110, then three frames 1001");
    applyStimulus(4'b0110, 4'd3);
    drain();
    applyStimulus(4'b1001, 4'd3);
    drain();

    $display("[TB] zero-frame request");
    applyStimulus(4'b1111, 4'd0);
    drain();

    $display("[TB] start and pattern change while busy are ignored");
    applyStimulus(4'b1100, 4'd2);
    @(negedge CLK);
    pattern = 4'b0011;
    repeats = 4'd5;
    start   = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    drain();

    $display("[TB] start during the done cycle is ignored");
    applyStimulus(4'b1010, 4'd1);
    repeat (4) @(negedge CLK);
    pattern = 4'b0111;
    start   = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    push_idle(2);
    drain();

    $display("[TB] single frames up to counter 15, then wrap");
    while (model_cnt != 4'd15) begin
      applyStimulus(4'b0101, 4'd1);
      drain();
    end
    checkOutput("cnt15_counter", 8'(counter_a), 8'd15);
    checkOutput("cnt15_ones", 8'(seg1_a), 8'(7'b1011011));
    checkOutput("cnt15_tens", 8'(seg2_a), 8'(7'b0110000));
    applyStimulus(4'b0101, 4'd1);
    drain();
    checkOutput("wrap_counter", 8'(counter_a), 8'd0);
    checkOutput("wrap_ones", 8'(seg1_a), 8'(7'b1111110));
    checkOutput("wrap_tens", 8'(seg2_a), 8'(7'b1111110));

    $display("[TB] reset in the middle of a frame");
    applyStimulus(4'b1011, 4'd1);
    @(negedge CLK);
    q_a.delete();
    q_b.delete();
    model_cnt = 4'd0;
    reset = 1'b1;
    push_idle(1);
    @(negedge CLK);
    reset = 1'b0;
    push_idle(1);
    drain();
    applyStimulus(4'b0110, 4'd2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
Serial pattern transmitter. It is the stimulus-side counterpart of the team's serial sequence-detector FSM, which takes one bit per CLK and counts detections on two 7-segment digits. This block emits a programmable PAT_W-bit pattern MSB-first, one bit per CLK, repeated a requested number of times with idle gaps. It counts completed frames and shows that count on two 7-segment digits. Its out/CLK pair drives the detector's in/CLK directly, so detection runs and board demos use a deterministic stream instead of $random.

Parameters:
PAT_W, 4, pattern width in bits (2..8)
GAP, 2, idle cycles between repeated frames (0..15); 0 means frames are back-to-back

Ports:
CLK  input  1  clock; all logic on posedge
reset  input  1  synchronous, active-high reset
start  input  1  request transmission; sampled only in IDLE
pattern  input  PAT_W  pattern to send; latched when start is accepted
repeat  input  4  number of frames to send (0..15); latched with pattern
out  output  1  serial data bit; connects to the detector's in
out_valid  output  1  high while out carries a pattern bit
busy  output  1  high in SEND and GAP
done  output  1  one-cycle pulse when the request completes
counter  output  4  completed frames since reset, modulo 16
a1,b1,c1,d1,e1,f1,g1  output  1 each  ones digit of counter (decimal), active-high segments
a2,b2,c2,d2,e2,f2,g2  output  1 each  tens digit of counter (0 or 1), active-high segments

Behaviour:
- All outputs are registered. State, out and out_valid update on the same edge.
- Reset (reset=1 at posedge):
  - state=IDLE, out=0, out_valid=0, busy=0, done=0, counter=0.
  - Both digits show 0: a..f=1, g=0.
  - Reset wins over every other event, including mid-frame and mid-gap; the in-flight request is discarded.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - Outputs: out=0, out_valid=0, busy=0.
  - start=1 with repeat!=0: latch pattern and repeat, set bit index to PAT_W-1, go to SEND. The first bit appears on out one cycle after the start edge.
  - start=1 with repeat=0: go to DONE. No bits are sent and counter is unchanged.
- SEND:
  - out = latched pattern[index], out_valid=1, busy=1. Each bit is held exactly one cycle; index decrements each cycle.
  - After bit 0: counter increments (15 wraps to 0) and remaining decrements.
  - If remaining becomes 0, go to DONE.
  - Otherwise go to GAP if GAP>0, or straight back to SEND with index reloaded to PAT_W-1 if GAP=0 (no bubble).
- GAP:
  - out=0, out_valid=0, busy=1.
  - Lasts exactly GAP cycles, then SEND with index reloaded.
- DONE:
  - done=1 for exactly one cycle, busy=0, out_valid=0, then IDLE.
  - A start in the DONE cycle is ignored; a new request is accepted from IDLE at the earliest.
- start while busy or in DONE: ignored. Latched pattern and repeat are unaffected by input changes during transmission.
- Frame timing: a request of R frames keeps busy high for R*PAT_W + (R-1)*GAP cycles. done follows the last bit by one cycle.
- 7-segment display:
  - ones = counter mod 10, tens = counter / 10. Combinational decode of the registered counter.
  - Active-high segment patterns (abcdefg):
    - 0 = 1111110
    - 1 = 0110000
    - 2 = 1101101
    - 3 = 1111001
    - 4 = 0110011
    - 5 = 1011011
    - 6 = 1011111
    - 7 = 1110000
    - 8 = 1111111
    - 9 = 1111011
- counter changes only on the last bit of a frame, never on a partial frame.

Test Plan:
1. Hold reset 3 cycles, start=1 during reset -> out=0, out_valid=0, busy=0, done=0, counter=0; both digits 1111110; stays IDLE after reset drops.
2. pattern=4'b1011, repeat=1, start 1 cycle -> out=1,0,1,1 with out_valid=1 on cycles +1..+4; done=1 on cycle +5 only; counter=1; ones=0110000, tens=1111110.
3. pattern=4'b0110, repeat=3, GAP=2 -> three frames, each followed by 2 cycles with out=0 and out_valid=0 except after the last; busy high for 16 cycles; counter +3. Repeat with GAP=0 -> 12 contiguous valid bits.
4. repeat=0 -> done on the next cycle, out_valid never high, counter unchanged. Pulse start mid-transmission and change pattern -> ignored, stream unchanged.
5. Run 15 single frames -> counter=15; tens=0110000, ones=1011011. One more frame -> counter=0, both digits 1111110.
6. Assert reset after 2 bits of a 4-bit frame -> next cycle all outputs at reset values, counter=0. A fresh start then transmits the full new pattern correctly.
